message_rotator: RTL
====================

Name: message_rotator

Overview:
- Source side of the 4-digit scan interface. Holds a circular message buffer of 4-bit character codes.
- Drives the four character slots char_an3..char_an0, which the display multiplexer consumes.
- Advances the visible window by one character every DELAY ticks of clkdv, giving constant-delay scrolling.
- The message can be rewritten at run time through a single-cycle write port.

Parameters:
- MSG_LEN, 16, number of characters in the circular buffer; legal range 4..16; pointer is 4 bits wide.
- DELAY, 50000, clkdv ticks per rotation step; legal range 1..2^24-1; counter is 24 bits wide.

Ports:
- clkdv  input  1  scan/system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  1 = delay counter and rotation enabled; 0 = freeze counter and pointer.
- wr_en  input  1  write strobe for the message buffer.
- wr_addr  input  4  buffer index to write; writes with wr_addr >= MSG_LEN are ignored.
- wr_data  input  4  character code to write.
- char_an3  output  4  leftmost digit = msg[ptr].
- char_an2  output  4  msg[(ptr+1) mod MSG_LEN].
- char_an1  output  4  msg[(ptr+2) mod MSG_LEN].
- char_an0  output  4  msg[(ptr+3) mod MSG_LEN].
- step  output  1  one-cycle pulse on the cycle the pointer advances.
- wrap  output  1  one-cycle pulse when the pointer wraps back to its start value; coincides with step.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - msg[i] = i for i < MSG_LEN; ptr = 0; cnt = 0; step = 0; wrap = 0.
  - char_an3..0 = 0, 1, 2, 3.
- Delay counter, on each rising clkdv edge with run = 1:
  - If cnt == DELAY-1: cnt <= 0, ptr advances, step <= 1.
  - Otherwise: cnt <= cnt+1, step <= 0.
  - DELAY = 1 gives a step every cycle while run = 1.
- run = 0: cnt and ptr hold; step = 0; wrap = 0. When run returns to 1, counting resumes from the held cnt.
- Pointer advance: ptr <= (ptr == MSG_LEN-1) ? 0 : ptr+1. wrap <= 1 exactly when ptr goes from MSG_LEN-1 to 0.
- Write port:
  - On an edge with wr_en = 1 and wr_addr < MSG_LEN: msg[wr_addr] <= wr_data.
  - Independent of run. A write on the same edge as a step performs both.
- Outputs:
  - Registered; reloaded every edge from the pre-edge msg and ptr (index arithmetic mod MSG_LEN).
  - Consequence: a pointer advance or buffer write at edge N appears on char_an* after edge N+1 (1-cycle latency).
  - step and wrap lead the new window by one cycle.
- Window crossing the buffer end wraps. Example: MSG_LEN = 16, ptr = 14 shows msg[14], msg[15], msg[0], msg[1].
- No X propagation: out-of-range indices never occur because all index arithmetic is mod MSG_LEN.

Optional Feature:
- Macro: ROTATOR_DIR_EN.
- When defined:
  - Adds input port dir (1 bit). dir = 0 rotates left as above.
  - dir = 1 rotates right: ptr <= (ptr == 0) ? MSG_LEN-1 : ptr-1.
  - wrap fires when ptr goes from 0 to MSG_LEN-1.
  - dir is sampled on the step edge only; changing dir does not reset cnt.
- When not defined: no dir port; left rotation only.

Test Plan:
- Reset then hold run = 0 for 10 cycles -> char_an3..0 stay 0, 1, 2, 3; step = 0 throughout.
- DELAY = 4, run = 1 from reset:
  - step pulses on cycles 4, 8, 12…
  - One cycle after the first step, outputs show 1, 2, 3, 4.
- DELAY = 4, MSG_LEN = 16, run for 64 cycles:
  - wrap pulses once, coincident with the 16th step.
  - The window at ptr = 14 shows E, F, 0, 1.
- Write msg[5] = 0xA while ptr = 2 and run = 0:
  - char_an0 changes from 5 to A exactly one cycle after the write edge.
  - A write with wr_addr = 12 while MSG_LEN = 12 has no effect.
- Assert run = 0 when cnt = 2, wait 20 cycles, release:
  - Next step occurs 2 cycles after release (DELAY = 4).
  - Assert reset mid-count -> outputs return immediately to 0, 1, 2, 3 and cnt = 0.
- ROTATOR_DIR_EN defined, dir = 1, DELAY = 1:
  - The first step moves ptr 0 -> 15 and wrap = 1.
  - The next window shows F, 0, 1, 2.

Source files
------------

// File: rtl/message_rotator.sv
// message_rotator
// Source side of the 4-digit scan interface. Holds a circular buffer of
// MSG_LEN 4-bit character codes and presents a 4-character window of it on
// char_an3..char_an0. The window start pointer advances by one character
// every DELAY clkdv ticks while run is high, giving constant-rate scrolling.
// The buffer can be rewritten at any time through a single-cycle write port.
//
// Optional feature macro: ROTATOR_DIR_EN
//   When defined, adds the dir input. dir = 1 scrolls right instead of left.
//   dir is only looked at on the edge where the pointer moves.
//
// Ports:
//   clkdv            scan/system clock, rising edge
//   reset            asynchronous, active-high reset
//   run              1 = counter and rotation enabled, 0 = freeze
//   dir              (ROTATOR_DIR_EN only) 0 = rotate left, 1 = rotate right
//   wr_en            buffer write strobe
//   wr_addr[3:0]     buffer index to write (ignored when >= MSG_LEN)
//   wr_data[3:0]     character code to write
//   char_an3..0[3:0] msg[ptr], msg[ptr+1], msg[ptr+2], msg[ptr+3] (mod MSG_LEN)
//   step             one-cycle pulse when the pointer advances
//   wrap             one-cycle pulse when the pointer wraps, coincides with step

module message_rotator #(
    parameter int MSG_LEN = 16,
    parameter int DELAY   = 50000
) (
    input  logic       clkdv,
    input  logic       reset,
    input  logic       run,
`ifdef ROTATOR_DIR_EN
    input  logic       dir,
`endif
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] char_an3,
    output logic [3:0] char_an2,
    output logic [3:0] char_an1,
    output logic [3:0] char_an0,
    output logic       step,
    output logic       wrap
);

    localparam logic [3:0]  PTR_LAST = 4'(MSG_LEN - 1);
    localparam logic [4:0]  LEN5     = 5'(MSG_LEN);
    localparam logic [23:0] CNT_TC   = 24'(DELAY - 1);

    logic [3:0]  r_msg [MSG_LEN];
    logic [3:0]  r_ptr;
    logic [23:0] r_cnt;

    logic        w_tc;
    logic [3:0]  w_ptr_nxt;
    logic        w_wrap_nxt;
    logic        w_wr_ok;
    logic [3:0]  w_idx1;
    logic [3:0]  w_idx2;
    logic [3:0]  w_idx3;

    // ptr < MSG_LEN and k <= 3 < MSG_LEN, so one conditional subtract
    // brings the sum back into range.
    function automatic logic [3:0] idx_add(input logic [3:0] ptr, input logic [1:0] k);
        logic [4:0] s;
        s = {1'b0, ptr} + {3'b000, k};
        if (s >= LEN5) begin
            s = s - LEN5;
        end
        return s[3:0];
    endfunction

    assign w_tc    = run && (r_cnt == CNT_TC);
    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < LEN5);
    assign w_idx1  = idx_add(r_ptr, 2'd1);
    assign w_idx2  = idx_add(r_ptr, 2'd2);
    assign w_idx3  = idx_add(r_ptr, 2'd3);

    always_comb begin
        w_ptr_nxt  = (r_ptr == PTR_LAST) ? 4'd0 : r_ptr + 4'd1;
        w_wrap_nxt = (r_ptr == PTR_LAST);
`ifdef ROTATOR_DIR_EN
        if (dir) begin
            w_ptr_nxt  = (r_ptr == 4'd0) ? PTR_LAST : r_ptr - 4'd1;
            w_wrap_nxt = (r_ptr == 4'd0);
        end
`endif
    end

    always_ff @(posedge clkdv or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_ptr <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (run) begin
                if (w_tc) begin
                    r_cnt <= '0;
                    r_ptr <= w_ptr_nxt;
                    step  <= 1'b1;
                    wrap  <= w_wrap_nxt;
                end else begin
                    r_cnt <= r_cnt + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clkdv or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                r_msg[i] <= 4'(i);
            end
        end else if (w_wr_ok) begin
            r_msg[wr_addr] <= wr_data;
        end
    end

    // Window is reloaded every edge from the pre-edge buffer and pointer,
    // so any pointer move or write shows up one cycle later.
    always_ff @(posedge clkdv or posedge reset) begin
        if (reset) begin
            char_an3 <= 4'd0;
            char_an2 <= 4'd1;
            char_an1 <= 4'd2;
            char_an0 <= 4'd3;
        end else begin
            char_an3 <= r_msg[r_ptr];
            char_an2 <= r_msg[w_idx1];
            char_an1 <= r_msg[w_idx2];
            char_an0 <= r_msg[w_idx3];
        end
    end

endmodule
